// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter
// Drives the register file's dual write port from two result sources:
//   - the single-cycle ALU pipe (one destination per result), and
//   - the multi-cycle mul/div unit (low word to Rd, optional high word to R15).
// Mul/div results are queued in a small FIFO and retired in cycles the ALU
// leaves idle. A starvation counter raises alu_stall so a queued result
// always gets a slot.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   alu_valid/rd/data   ALU result offered this cycle
//   alu_stall           registered; upstream holds its ALU result while high
//   md_valid/rd/lo/hi/dual, md_ready   mul/div result handshake into the FIFO
//   reg_write, write_op2                 register file write enables
//   write_reg1/data1, write_reg2/data2   port-1 / port-2 index and data
//   fifo_count          current FIFO occupancy
module wb_write_arbiter #(
    parameter int         DEPTH       = 2,
    parameter int         STALL_LIMIT = 3,
    parameter logic [3:0] R15_IDX     = 4'd15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alu_valid,
    input  logic [3:0]              alu_rd,
    input  logic [15:0]             alu_data,
    output logic                    alu_stall,
    input  logic                    md_valid,
    output logic                    md_ready,
    input  logic [3:0]              md_rd,
    input  logic [15:0]             md_lo,
    input  logic [15:0]             md_hi,
    input  logic                    md_dual,
    output logic                    reg_write,
    output logic                    write_op2,
    output logic [3:0]              write_reg1,
    output logic [15:0]             write_data1,
    output logic [3:0]              write_reg2,
    output logic [15:0]             write_data2,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STALL_LIMIT + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [SW-1:0] LIMIT_C = SW'(STALL_LIMIT);

    typedef struct packed {
        logic [3:0]  rd;
        logic [15:0] lo;
        logic [15:0] hi;
        logic        dual;
    } mdEntry_t;

    typedef enum logic [1:0] {GRANT_IDLE, GRANT_ALU, GRANT_MD} grant_t;

    mdEntry_t        mem_q [DEPTH];
    mdEntry_t        headEntry;
    logic [PW-1:0]   wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            stall_q, stall_d;
    logic            regWrite_q, regWrite_d, op2_q, op2_d;
    logic [3:0]      reg1_q, reg1_d, reg2_q, reg2_d;
    logic [15:0]     data1_q, data1_d, data2_q, data2_d;
    logic            mdPush, mdPop, fifoEmpty;
    grant_t          grant;

    // Ready looks only at the registered count, so a full FIFO refuses a
    // push even in a cycle where it is also popping.
    assign md_ready = rst && (count_q < DEPTH_C);

    // Arbitration: an unstalled ALU result wins; otherwise the FIFO head.
    // A stalled ALU result is left for upstream to re-present.
    always_comb begin
        mdPush    = md_valid && md_ready;
        fifoEmpty = (count_q == '0);
        headEntry = mem_q[rdPtr_q];
        if (alu_valid && !stall_q) begin
            grant = GRANT_ALU;
        end else if (!fifoEmpty) begin
            grant = GRANT_MD;
        end else begin
            grant = GRANT_IDLE;
        end
        mdPop = (grant == GRANT_MD);
    end

    // FIFO bookkeeping and starvation tracking.
    always_comb begin
        wrPtr_d  = wrPtr_q;
        rdPtr_d  = rdPtr_q;
        count_d  = count_q;
        starve_d = starve_q;
        stall_d  = stall_q;

        if (mdPush) begin
            wrPtr_d = wrPtr_q + PW'(1);
        end
        if (mdPop) begin
            rdPtr_d = rdPtr_q + PW'(1);
        end
        if (mdPush && !mdPop) begin
            count_d = count_q + CW'(1);
        end else if (!mdPush && mdPop) begin
            count_d = count_q - CW'(1);
        end

        if (fifoEmpty || mdPop) begin
            starve_d = '0;
        end else if (grant == GRANT_ALU && starve_q != LIMIT_C) begin
            starve_d = starve_q + SW'(1);
        end

        // Stall rises together with the counter reaching the limit and holds
        // until the head is popped (which the stall itself guarantees).
        if (fifoEmpty || mdPop) begin
            stall_d = 1'b0;
        end else if (starve_d == LIMIT_C) begin
            stall_d = 1'b1;
        end
    end

    // Next write-port values; idle cycles keep index/data stable.
    always_comb begin
        regWrite_d = 1'b0;
        op2_d      = 1'b0;
        reg1_d     = reg1_q;
        data1_d    = data1_q;
        reg2_d     = reg2_q;
        data2_d    = data2_q;
        unique case (grant)
            GRANT_ALU: begin
                regWrite_d = 1'b1;
                reg1_d     = alu_rd;
                data1_d    = alu_data;
            end
            GRANT_MD: begin
                regWrite_d = 1'b1;
                reg2_d     = 4'd0;
                data2_d    = 16'd0;
                if (headEntry.dual && headEntry.rd == R15_IDX) begin
                    // Both words target R15: the high word is the one kept.
                    reg1_d  = R15_IDX;
                    data1_d = headEntry.hi;
                end else begin
                    reg1_d  = headEntry.rd;
                    data1_d = headEntry.lo;
                    if (headEntry.dual) begin
                        op2_d   = 1'b1;
                        reg2_d  = R15_IDX;
                        data2_d = headEntry.hi;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            stall_q    <= 1'b0;
            regWrite_q <= 1'b0;
            op2_q      <= 1'b0;
            reg1_q     <= 4'd0;
            data1_q    <= 16'd0;
            reg2_q     <= 4'd0;
            data2_q    <= 16'd0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            stall_q    <= stall_d;
            regWrite_q <= regWrite_d;
            op2_q      <= op2_d;
            reg1_q     <= reg1_d;
            data1_q    <= data1_d;
            reg2_q     <= reg2_d;
            data2_q    <= data2_d;
        end
    end

    // Entry storage needs no reset: occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (mdPush) begin
            mem_q[wrPtr_q] <= '{rd: md_rd, lo: md_lo, hi: md_hi, dual: md_dual};
        end
    end

    assign alu_stall   = stall_q;
    assign reg_write   = regWrite_q;
    assign write_op2   = op2_q;
    assign write_reg1  = reg1_q;
    assign write_data1 = data1_q;
    assign write_reg2  = reg2_q;
    assign write_data2 = data2_q;
    assign fifo_count  = count_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb_wb_write_arbiter
// Table-driven sequence for wb_write_arbiter: each record holds the inputs
// for one cycle and the write-port state expected after that clock edge.
// Hand-written sequences cover reset, full-FIFO push/pop and reset with
// buffered entries.
module tb_wb_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [3:0]  alu_rd;
    logic [15:0] alu_data;
    logic        alu_stall;
    logic        md_valid;
    logic        md_ready;
    logic [3:0]  md_rd;
    logic [15:0] md_lo;
    logic [15:0] md_hi;
    logic        md_dual;
    logic        reg_write;
    logic        write_op2;
    logic [3:0]  write_reg1;
    logic [15:0] write_data1;
    logic [3:0]  write_reg2;
    logic [15:0] write_data2;
    logic [1:0]  fifo_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        av;
        logic [3:0]  ard;
        logic [15:0] adata;
        logic        mv;
        logic [3:0]  mrd;
        logic [15:0] mlo;
        logic [15:0] mhi;
        logic        mdual;
        logic        rw;
        logic        op2;
        logic [3:0]  r1;
        logic [15:0] d1;
        logic [3:0]  r2;
        logic [15:0] d2;
        logic        stall;
        logic [1:0]  cnt;
        logic        rdy;
        logic        chkP2;
    } vec_t;

    typedef struct {
        logic [3:0]  rd;
        logic [15:0] lo;
        logic [15:0] hi;
        logic        dual;
    } md_t;

    vec_t vecs[$];
    vec_t expQ[$];
    md_t  mdQ[$];

    wb_write_arbiter #(.DEPTH(2), .STALL_LIMIT(3), .R15_IDX(4'd15)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .alu_stall(alu_stall),
        .md_valid(md_valid), .md_ready(md_ready), .md_rd(md_rd),
        .md_lo(md_lo), .md_hi(md_hi), .md_dual(md_dual),
        .reg_write(reg_write), .write_op2(write_op2),
        .write_reg1(write_reg1), .write_data1(write_data1),
        .write_reg2(write_reg2), .write_data2(write_data2),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    function automatic vec_t mkVec(
        input logic av, input logic [3:0] ard, input logic [15:0] adata,
        input logic mv, input logic [3:0] mrd, input logic [15:0] mlo,
        input logic [15:0] mhi, input logic mdual,
        input logic rw, input logic op2, input logic [3:0] r1,
        input logic [15:0] d1, input logic [3:0] r2, input logic [15:0] d2,
        input logic stall, input logic [1:0] cnt, input logic rdy,
        input logic chkP2);
        vec_t v;
        v.av = av; v.ard = ard; v.adata = adata;
        v.mv = mv; v.mrd = mrd; v.mlo = mlo; v.mhi = mhi; v.mdual = mdual;
        v.rw = rw; v.op2 = op2; v.r1 = r1; v.d1 = d1; v.r2 = r2; v.d2 = d2;
        v.stall = stall; v.cnt = cnt; v.rdy = rdy; v.chkP2 = chkP2;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic driveInputs(input logic av, input logic [3:0] ard, input logic [15:0] adata,
                               input logic mv, input logic [3:0] mrd, input logic [15:0] mlo,
                               input logic [15:0] mhi, input logic mdual);
        alu_valid = av; alu_rd = ard; alu_data = adata;
        md_valid = mv; md_rd = mrd; md_lo = mlo; md_hi = mhi; md_dual = mdual;
    endtask

    // Drive one table record, queue its expectation, and advance one edge.
    task automatic applyStimulus(input vec_t v);
        driveInputs(v.av, v.ard, v.adata, v.mv, v.mrd, v.mlo, v.mhi, v.mdual);
        expQ.push_back(v);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input int idx);
        vec_t e;
        string tag;
        if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL vec%0d: got no queued expectation expected one", idx);
            return;
        end
        e = expQ.pop_front();
        tag = $sformatf("vec%0d", idx);
        cmp({tag, ".reg_write"}, 16'(reg_write), 16'(e.rw));
        cmp({tag, ".write_op2"}, 16'(write_op2), 16'(e.op2));
        cmp({tag, ".write_reg1"}, 16'(write_reg1), 16'(e.r1));
        cmp({tag, ".write_data1"}, write_data1, e.d1);
        if (e.chkP2) begin
            cmp({tag, ".write_reg2"}, 16'(write_reg2), 16'(e.r2));
            cmp({tag, ".write_data2"}, write_data2, e.d2);
        end
        cmp({tag, ".alu_stall"}, 16'(alu_stall), 16'(e.stall));
        cmp({tag, ".fifo_count"}, 16'(fifo_count), 16'(e.cnt));
        cmp({tag, ".md_ready"}, 16'(md_ready), 16'(e.rdy));
    endtask

    // Compare the write port against the oldest mul/div entry expected out.
    task automatic expectMdWrite(input string name);
        md_t m;
        if (mdQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL %s: got empty md scoreboard expected an entry", name);
            return;
        end
        m = mdQ.pop_front();
        cmp({name, ".reg_write"}, 16'(reg_write), 16'd1);
        cmp({name, ".write_reg1"}, 16'(write_reg1), 16'(m.rd));
        cmp({name, ".write_data1"}, write_data1, m.lo);
        cmp({name, ".write_op2"}, 16'(write_op2), 16'(m.dual));
        cmp({name, ".write_reg2"}, 16'(write_reg2), m.dual ? 16'd15 : 16'd0);
        cmp({name, ".write_data2"}, write_data2, m.dual ? m.hi : 16'd0);
    endtask

    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        md_t e;

        // Reset held with both sources active.
        rst = 1'b0;
        driveInputs(1'b1, 4'd9, 16'hFFFF, 1'b1, 4'd9, 16'hFFFF, 16'hFFFF, 1'b1);
        #1;
        cmp("rst.md_ready", 16'(md_ready), 16'd0);
        stepEdge();
        stepEdge();
        cmp("rst.reg_write", 16'(reg_write), 16'd0);
        cmp("rst.write_op2", 16'(write_op2), 16'd0);
        cmp("rst.write_reg1", 16'(write_reg1), 16'd0);
        cmp("rst.write_data1", write_data1, 16'd0);
        cmp("rst.write_reg2", 16'(write_reg2), 16'd0);
        cmp("rst.write_data2", write_data2, 16'd0);
        cmp("rst.alu_stall", 16'(alu_stall), 16'd0);
        cmp("rst.fifo_count", 16'(fifo_count), 16'd0);
        cmp("rst.md_ready_held", 16'(md_ready), 16'd0);

        driveInputs(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 16'd0, 1'b0);
        rst = 1'b1;
        #1;
        cmp("release.md_ready", 16'(md_ready), 16'd1);
        stepEdge();
        cmp("release.reg_write", 16'(reg_write), 16'd0);

        //                av ard  adata     mv mrd mlo       mhi       dl  rw op2 r1     d1        r2     d2     st cnt rdy p2
        vecs.push_back(mkVec(1, 3, 16'h1234, 0, 0, 16'h0000, 16'h0000, 0,  1, 0, 4'd3, 16'h1234, 4'd0,  16'h0000, 0, 0, 1, 1));
        vecs.push_back(mkVec(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0,  0, 0, 4'd3, 16'h1234, 4'd0,  16'h0000, 0, 0, 1, 1));
        vecs.push_back(mkVec(0, 0, 16'h0000, 1, 5, 16'h00AB, 16'h0012, 1,  0, 0, 4'd3, 16'h1234, 4'd0,  16'h0000, 0, 1, 1, 1));
        vecs.push_back(mkVec(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0,  1, 1, 4'd5, 16'h00AB, 4'd15, 16'h0012, 0, 0, 1, 1));
        vecs.push_back(mkVec(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0,  0, 0, 4'd5, 16'h00AB, 4'd15, 16'h0012, 0, 0, 1, 1));
        vecs.push_back(mkVec(1, 1, 16'h1111, 1, 7, 16'h0A0A, 16'h7777, 0,  1, 0, 4'd1, 16'h1111, 4'd15, 16'h0012, 0, 1, 1, 1));
        vecs.push_back(mkVec(1, 2, 16'h2222, 1, 8, 16'h0B0B, 16'h8888, 1,  1, 0, 4'd2, 16'h2222, 4'd15, 16'h0012, 0, 2, 0, 1));
        vecs.push_back(mkVec(1, 3, 16'h3333, 1, 9, 16'hC0C0, 16'h9999, 1,  1, 0, 4'd3, 16'h3333, 4'd15, 16'h0012, 0, 2, 0, 1));
        vecs.push_back(mkVec(1, 4, 16'h4444, 0, 0, 16'h0000, 16'h0000, 0,  1, 0, 4'd4, 16'h4444, 4'd15, 16'h0012, 1, 2, 0, 1));
        vecs.push_back(mkVec(1, 5, 16'h5555, 0, 0, 16'h0000, 16'h0000, 0,  1, 0, 4'd7, 16'h0A0A, 4'd0,  16'h0000, 0, 1, 1, 1));
        vecs.push_back(mkVec(1, 5, 16'h5555, 0, 0, 16'h0000, 16'h0000, 0,  1, 0, 4'd5, 16'h5555, 4'd0,  16'h0000, 0, 1, 1, 1));
        vecs.push_back(mkVec(1, 6, 16'h6666, 0, 0, 16'h0000, 16'h0000, 0,  1, 0, 4'd6, 16'h6666, 4'd0,  16'h0000, 0, 1, 1, 1));
        vecs.push_back(mkVec(1, 7, 16'h7777, 0, 0, 16'h0000, 16'h0000, 0,  1, 0, 4'd7, 16'h7777, 4'd0,  16'h0000, 1, 1, 1, 1));
        vecs.push_back(mkVec(1, 8, 16'h8888, 0, 0, 16'h0000, 16'h0000, 0,  1, 1, 4'd8, 16'h0B0B, 4'd15, 16'h8888, 0, 0, 1, 1));
        vecs.push_back(mkVec(1, 8, 16'h8888, 0, 0, 16'h0000, 16'h0000, 0,  1, 0, 4'd8, 16'h8888, 4'd15, 16'h8888, 0, 0, 1, 1));
        vecs.push_back(mkVec(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0,  0, 0, 4'd8, 16'h8888, 4'd15, 16'h8888, 0, 0, 1, 1));
        vecs.push_back(mkVec(0, 0, 16'h0000, 1, 15, 16'h0001, 16'hBEEF, 1, 0, 0, 4'd8, 16'h8888, 4'd15, 16'h8888, 0, 1, 1, 1));
        vecs.push_back(mkVec(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0,  1, 0, 4'd15, 16'hBEEF, 4'd0, 16'h0000, 0, 0, 1, 0));
        vecs.push_back(mkVec(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0,  0, 0, 4'd15, 16'hBEEF, 4'd0, 16'h0000, 0, 0, 1, 0));
        vecs.push_back(mkVec(1, 0, 16'hA5A5, 0, 0, 16'h0000, 16'h0000, 0,  1, 0, 4'd0, 16'hA5A5, 4'd0,  16'h0000, 0, 0, 1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput(i);
        end

        // Full FIFO: a pop and a refused push in the same cycle.
        driveInputs(1'b1, 4'd1, 16'h0101, 1'b1, 4'd2, 16'h1000, 16'h2000, 1'b0);
        e = '{rd: 4'd2, lo: 16'h1000, hi: 16'h2000, dual: 1'b0};
        mdQ.push_back(e);
        stepEdge();
        driveInputs(1'b1, 4'd1, 16'h0102, 1'b1, 4'd3, 16'h3000, 16'h4000, 1'b1);
        e = '{rd: 4'd3, lo: 16'h3000, hi: 16'h4000, dual: 1'b1};
        mdQ.push_back(e);
        stepEdge();
        cmp("full.fifo_count", 16'(fifo_count), 16'd2);
        driveInputs(1'b0, 4'd0, 16'h0000, 1'b1, 4'd4, 16'h5000, 16'h6000, 1'b1);
        cmp("full.md_ready", 16'(md_ready), 16'd0);
        stepEdge();
        cmp("full.pop_count", 16'(fifo_count), 16'd1);
        expectMdWrite("full.first");
        cmp("retry.md_ready", 16'(md_ready), 16'd1);
        e = '{rd: 4'd4, lo: 16'h5000, hi: 16'h6000, dual: 1'b1};
        mdQ.push_back(e);
        stepEdge();
        cmp("retry.fifo_count", 16'(fifo_count), 16'd1);
        expectMdWrite("retry.second");
        driveInputs(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 16'h0000, 1'b0);
        stepEdge();
        cmp("retry.drained", 16'(fifo_count), 16'd0);
        expectMdWrite("retry.third");

        // Reset with two buffered entries discards them.
        driveInputs(1'b1, 4'd6, 16'h0606, 1'b1, 4'd10, 16'hAAAA, 16'hBBBB, 1'b1);
        stepEdge();
        driveInputs(1'b1, 4'd6, 16'h0607, 1'b1, 4'd11, 16'hCCCC, 16'hDDDD, 1'b0);
        stepEdge();
        cmp("midrst.prefill", 16'(fifo_count), 16'd2);
        #2;
        rst = 1'b0;
        #1;
        cmp("midrst.fifo_count", 16'(fifo_count), 16'd0);
        cmp("midrst.reg_write", 16'(reg_write), 16'd0);
        cmp("midrst.write_data1", write_data1, 16'd0);
        cmp("midrst.md_ready", 16'(md_ready), 16'd0);
        driveInputs(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 16'h0000, 1'b0);
        stepEdge();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            stepEdge();
            cmp($sformatf("postrst%0d.reg_write", k), 16'(reg_write), 16'd0);
            cmp($sformatf("postrst%0d.fifo_count", k), 16'(fifo_count), 16'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
